dispatch_credit_arb: RTL and testbench

Shares one execution unit (e.g. the SFU) between NUM_REQS dispatch lanes, one per issue slot.
- Grants one lane per cycle, round-robin, and registers the winner into a 2-entry output buffer.
- Limits how many instructions can be outstanding at the unit with a credit counter; the unit returns a credit by pulsing done_in.
- Sits between the per-slot dispatch buffers and the shared unit's dispatch input.

---
 rtl/dispatch_credit_arb.sv | 168 ++++++++++++++++
 tb/tb_dispatch_credit_arb.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_credit_arb.sv
// dispatch_credit_arb
//   Shares one execution unit between NUM_REQS dispatch lanes. Each cycle one
//   requesting lane is granted round-robin. The winner's payload and lane index
//   are registered into a 2-entry FIFO that feeds the unit. A credit counter
//   bounds how many instructions are outstanding at the unit. A credit is taken
//   when an entry is accepted into the FIFO. It is returned when the unit
//   pulses done_in.
//
// Ports
//   clk, reset   clock; synchronous active-high reset
//   valid_in     per-lane request valid
//   data_in      per-lane payload, lane i at [i*DATAW +: DATAW]
//   ready_in     per-lane accept (one-hot or zero)
//   valid_out    FIFO head valid
//   data_out     FIFO head payload
//   sel_out      FIFO head lane index
//   ready_out    unit accepts the FIFO head
//   done_in      unit finished one instruction (returns one credit)
//   credits_out  credits currently available
module dispatch_credit_arb #(
  parameter  int NUM_REQS = 4,
  parameter  int DATAW    = 64,
  parameter  int CREDITS  = 4,
  localparam int SELW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int CRW      = $clog2(CREDITS + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       valid_in,
  input  logic [NUM_REQS*DATAW-1:0] data_in,
  output logic [NUM_REQS-1:0]       ready_in,
  output logic                      valid_out,
  output logic [DATAW-1:0]          data_out,
  output logic [SELW-1:0]           sel_out,
  input  logic                      ready_out,
  input  logic                      done_in,
  output logic [CRW-1:0]            credits_out
);

  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  grant;
  logic [SELW-1:0]  scan_idx;
  logic             found;
  logic             any_valid;
  logic             can_accept;
  logic             push;
  logic             pop;
  logic [DATAW-1:0] grant_data;
  logic [CRW-1:0]   credits;

  // FIFO: _p0 is the head, _p1 is the entry behind it.
  logic             vld_p0;
  logic             vld_p1;
  logic             vld_p0_next;
  logic             vld_p1_next;
  logic [DATAW-1:0] data_p0;
  logic [DATAW-1:0] data_p1;
  logic [SELW-1:0]  sel_p0;
  logic [SELW-1:0]  sel_p1;

  // Lane index + 1, wrapping at NUM_REQS. This also handles non-power-of-two
  // lane counts.
  function automatic logic [SELW-1:0] wrap_inc(input logic [SELW-1:0] idx);
    logic [SELW-1:0] res;
    if (NUM_REQS == 1 || int'(idx) >= NUM_REQS - 1) begin
      res = '0;
    end else begin
      res = idx + SELW'(1);
    end
    return res;
  endfunction

  // Credit update. A take and a give in the same cycle cancel out. A give at
  // full credit saturates at CREDITS instead of wrapping.
  function automatic logic [CRW-1:0] credit_next(input logic [CRW-1:0] cur,
                                                 input logic           take,
                                                 input logic           give);
    logic [CRW-1:0] res;
    res = cur;
    if (take && !give) begin
      res = cur - CRW'(1);
    end else if (give && !take && cur != CRW'(CREDITS)) begin
      res = cur + CRW'(1);
    end
    return res;
  endfunction

  // Round-robin scan: start at rr_ptr and take the first valid lane.
  always_comb begin
    any_valid = |valid_in;
    grant     = rr_ptr;
    scan_idx  = rr_ptr;
    found     = 1'b0;
    for (int k = 0; k < NUM_REQS; k++) begin
      if (!found && valid_in[scan_idx]) begin
        grant = scan_idx;
        found = 1'b1;
      end
      scan_idx = wrap_inc(scan_idx);
    end
  end

  assign grant_data = data_in[int'(grant)*DATAW +: DATAW];

  // There is no bypass: a full FIFO blocks acceptance even when the head pops
  // in the same cycle. This keeps ready_out out of the ready_in path.
  assign can_accept = any_valid && (credits != '0) && !vld_p1;
  assign push       = can_accept;
  assign pop        = vld_p0 && ready_out;

  always_comb begin
    ready_in = '0;
    if (can_accept) begin
      ready_in[grant] = 1'b1;
    end
  end

  // Occupancy is encoded as the two valid bits. vld_p1 implies vld_p0.
  assign vld_p0_next = push | vld_p1 | (vld_p0 & ~pop);
  assign vld_p1_next = (vld_p1 & ~pop) | (vld_p0 & ~pop & push);

  // ---- control registers: arbiter pointer, credits, FIFO occupancy ----
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr  <= '0;
      credits <= CRW'(CREDITS);
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      if (push) begin
        rr_ptr <= wrap_inc(grant);
      end
      credits <= credit_next(credits, push, done_in);
      vld_p0  <= vld_p0_next;
      vld_p1  <= vld_p1_next;
    end
  end

  // ---- FIFO payload registers (qualified by vld_p0/vld_p1 only) ----
  always_ff @(posedge clk) begin
    if (pop && vld_p1) begin
      data_p0 <= data_p1;
      sel_p0  <= sel_p1;
    end else if (push && (!vld_p0 || pop)) begin
      data_p0 <= grant_data;
      sel_p0  <= grant;
    end
    if (push && vld_p0 && !pop) begin
      data_p1 <= grant_data;
      sel_p1  <= grant;
    end
  end

  // A credit returned while none is outstanding means the unit and this
  // block disagree about in-flight work.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(done_in && !push && credits == CRW'(CREDITS)))
        else $error("dispatch_credit_arb: done_in with no outstanding credit");
    end
  end

  assign valid_out   = vld_p0;
  assign data_out    = data_p0;
  assign sel_out     = sel_p0;
  assign credits_out = credits;

endmodule

// File: tb/tb_dispatch_credit_arb.sv
module tb_dispatch_credit_arb;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int CR = 4;
  localparam int SW = 2;
  localparam int CW = 3;

  logic              clk;
  logic              reset;
  logic [N-1:0]      valid_in;
  logic [N*DW-1:0]   data_in;
  logic [N-1:0]      ready_in;
  logic              valid_out;
  logic [DW-1:0]     data_out;
  logic [SW-1:0]     sel_out;
  logic              ready_out;
  logic              done_in;
  logic [CW-1:0]     credits_out;

  int checks   = 0;
  int failures = 0;

  // Reference model: FIFO contents as queues, plain integer credits and pointer.
  logic [DW-1:0] qd[$];
  int            qs[$];
  int            cred;
  int            rr;

  dispatch_credit_arb #(.NUM_REQS(N), .DATAW(DW), .CREDITS(CR)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .ready_in   (ready_in),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .sel_out    (sel_out),
    .ready_out  (ready_out),
    .done_in    (done_in),
    .credits_out(credits_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, compare against the model, advance the model.
  task automatic step(input logic [N-1:0] v, input logic ro, input logic dn,
                      input logic rs, output bit fired);
    int            g;
    int            idx;
    bit            can;
    logic [N-1:0]  exp_rdy;
    logic [DW-1:0] gd;
    for (int i = 0; i < N; i++) data_in[i*DW +: DW] = {$urandom, $urandom};
    valid_in  = v;
    ready_out = ro;
    done_in   = dn;
    reset     = rs;
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (rr + k) % N;
      if (g < 0 && v[idx]) g = idx;
    end
    can = (g >= 0) && (cred > 0) && (qd.size() < 2);
    exp_rdy = '0;
    gd = '0;
    if (can) begin
      exp_rdy[g] = 1'b1;
      gd = data_in[g*DW +: DW];
    end
    check("ready_in", 64'(ready_in), 64'(exp_rdy));
    check("valid_out", 64'(valid_out), 64'(qd.size() != 0));
    check("credits_out", 64'(credits_out), 64'(cred));
    if (qd.size() != 0) begin
      check("data_out", data_out, qd[0]);
      check("sel_out", 64'(sel_out), 64'(qs[0]));
    end
    fired = (qd.size() != 0) && ro;
    @(posedge clk);
    if (rs) begin
      qd.delete();
      qs.delete();
      cred = CR;
      rr   = 0;
    end else begin
      if (fired) begin
        void'(qd.pop_front());
        void'(qs.pop_front());
      end
      if (can) begin
        qd.push_back(gd);
        qs.push_back(g);
        rr = (g + 1) % N;
      end
      cred = cred - int'(can) + int'(dn);
    end
    @(negedge clk);
  endtask

  initial begin
    bit f;
    bit fh[0:31];
    bit dn;
    clk = 0; reset = 1; valid_in = '0; data_in = '0; ready_out = 0; done_in = 0;
    cred = CR; rr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state
    check("rst_valid_out", 64'(valid_out), 64'd0);
    check("rst_credits", 64'(credits_out), 64'(CR));
    check("rst_ready_in", 64'(ready_in), 64'd0);
    step(4'b0000, 1'b0, 1'b0, 1'b0, f);

    // Single lane 2, done two cycles after each fire
    step(4'b0000, 1'b0, 1'b0, 1'b1, f);
    for (int i = 0; i < 24; i++) begin
      dn = (i >= 2) ? fh[i-2] : 1'b0;
      step(4'b0100, 1'b1, dn, 1'b0, f);
      fh[i] = f;
      check("t1_credits_nonzero", 64'(credits_out != 0), 64'd1);
    end

    // Round-robin fairness
    step(4'b0000, 1'b0, 1'b0, 1'b1, f);
    for (int i = 0; i < 12; i++) begin
      step(4'b1111, 1'b1, (i >= 2), 1'b0, f);
      check("t2_rr_next", 64'(ready_in), 64'(4'b0001 << ((i + 1) % 4)));
    end

    // Credit exhaustion
    step(4'b0000, 1'b0, 1'b0, 1'b1, f);
    for (int i = 0; i < 4; i++) step(4'b1111, 1'b1, 1'b0, 1'b0, f);
    check("t3_credits_zero", 64'(credits_out), 64'd0);
    check("t3_blocked", 64'(ready_in), 64'd0);
    step(4'b1111, 1'b1, 1'b0, 1'b0, f);
    step(4'b1111, 1'b1, 1'b1, 1'b0, f);
    check("t3_credit_back", 64'(credits_out), 64'd1);
    check("t3_one_more", 64'(ready_in), 64'b0001);
    step(4'b1111, 1'b1, 1'b0, 1'b0, f);
    check("t3_credits_zero2", 64'(credits_out), 64'd0);
    check("t3_blocked2", 64'(ready_in), 64'd0);

    // Backpressure, no same-cycle bypass
    step(4'b0000, 1'b0, 1'b0, 1'b1, f);
    step(4'b1111, 1'b0, 1'b0, 1'b0, f);
    step(4'b1111, 1'b0, 1'b0, 1'b0, f);
    check("t4_full_valid", 64'(valid_out), 64'd1);
    check("t4_full_blocked", 64'(ready_in), 64'd0);
    step(4'b1111, 1'b1, 1'b0, 1'b0, f);
    check("t4_after_pop", 64'(ready_in), 64'b0100);
    step(4'b1111, 1'b0, 1'b0, 1'b0, f);

    // Simultaneous accept and done at credits=1
    step(4'b0000, 1'b0, 1'b0, 1'b1, f);
    for (int i = 0; i < 3; i++) step(4'b0001, 1'b1, 1'b0, 1'b0, f);
    check("t5_credits_one", 64'(credits_out), 64'd1);
    step(4'b0001, 1'b1, 1'b1, 1'b0, f);
    check("t5_credits_hold", 64'(credits_out), 64'd1);

    // Reset mid-stream with two buffered entries and one credit left
    step(4'b0000, 1'b0, 1'b0, 1'b1, f);
    step(4'b1111, 1'b0, 1'b0, 1'b0, f);
    step(4'b1111, 1'b1, 1'b0, 1'b0, f);
    step(4'b1111, 1'b0, 1'b0, 1'b0, f);
    check("t6_pre_valid", 64'(valid_out), 64'd1);
    check("t6_pre_credits", 64'(credits_out), 64'd1);
    step(4'b1111, 1'b0, 1'b0, 1'b1, f);
    check("t6_valid_cleared", 64'(valid_out), 64'd0);
    check("t6_credits_restored", 64'(credits_out), 64'(CR));
    check("t6_lane0_first", 64'(ready_in), 64'b0001);
    step(4'b1111, 1'b0, 1'b0, 1'b0, f);
    check("t6_sel0", 64'(sel_out), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] v;
      logic         ro;
      logic         rs;
      v  = N'($urandom);
      ro = ($urandom_range(0, 3) != 0);
      dn = ($urandom_range(0, 2) == 0) && (cred < CR);
      rs = ($urandom_range(0, 99) == 0);
      step(v, ro, dn, rs, f);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
